// File: rtl/lsu_fault_report_if.sv
// Signal bundle between the LSU address-check stage, the fault reporter and the TLU.
// The slave modport is the reporter's view; the master modport is the LSU/TLU side.
interface lsu_fault_report_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
);
  logic              lsu_pkt_valid_dc1;
  logic              lsu_pkt_dma_dc1;
  logic              lsu_pkt_store_dc1;
  logic [ADDR_W-1:0] start_addr_dc1;
  logic              access_fault_dc1;
  logic              misaligned_fault_dc1;
  logic              lsu_freeze_dc3;
  logic              dec_tlu_flush_lower_wb;
  logic              tlu_fault_ack;
  logic              lsu_fault_valid;
  logic [3:0]        lsu_fault_cause;
  logic [ADDR_W-1:0] lsu_fault_addr;
  logic              lsu_fault_overflow;
  logic [CNT_W-1:0]  lsu_fault_cnt;

  modport slave (
    input  lsu_pkt_valid_dc1, lsu_pkt_dma_dc1, lsu_pkt_store_dc1, start_addr_dc1,
           access_fault_dc1, misaligned_fault_dc1, lsu_freeze_dc3,
           dec_tlu_flush_lower_wb, tlu_fault_ack,
    output lsu_fault_valid, lsu_fault_cause, lsu_fault_addr,
           lsu_fault_overflow, lsu_fault_cnt
  );

  modport master (
    output lsu_pkt_valid_dc1, lsu_pkt_dma_dc1, lsu_pkt_store_dc1, start_addr_dc1,
           access_fault_dc1, misaligned_fault_dc1, lsu_freeze_dc3,
           dec_tlu_flush_lower_wb, tlu_fault_ack,
    input  lsu_fault_valid, lsu_fault_cause, lsu_fault_addr,
           lsu_fault_overflow, lsu_fault_cnt
  );
endinterface

// File: rtl/lsu_fault_report.sv
// Stages dc1 address-check faults to dc3, captures the first surviving one and
// presents it to the TLU as mcause/mtval under a valid/ack handshake.
module lsu_fault_report #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_l,
  lsu_fault_report_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    REPORT = 1'b1
  } state_e;

  // dc1 qualification: DMA accesses never report; access fault outranks misaligned.
  logic              fault_dc1;
  logic [3:0]        cause_dc1;

  assign fault_dc1 = bus.lsu_pkt_valid_dc1 & ~bus.lsu_pkt_dma_dc1 &
                     (bus.access_fault_dc1 | bus.misaligned_fault_dc1);
  assign cause_dc1 = {1'b0, 1'b1, bus.lsu_pkt_store_dc1, bus.access_fault_dc1};

  logic              dc2_fault, dc3_fault;
  logic [3:0]        dc2_cause, dc3_cause;
  logic [ADDR_W-1:0] dc2_addr,  dc3_addr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its source, regardless of statement order.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      dc2_fault <= 1'b0;
      dc3_fault <= 1'b0;
    end else if (bus.dec_tlu_flush_lower_wb) begin
      dc2_fault <= 1'b0;
      dc3_fault <= 1'b0;
    end else if (!bus.lsu_freeze_dc3) begin
      dc2_fault <= fault_dc1;
      dc3_fault <= dc2_fault;
    end
  end

  // NOTE: the payload registers are qualified by the fault bits, so their reset
  // is not functionally needed; it is kept because it is cheap and aids debug.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      dc2_cause <= '0;
      dc3_cause <= '0;
      dc2_addr  <= '0;
      dc3_addr  <= '0;
    end else if (!bus.lsu_freeze_dc3) begin
      dc2_cause <= cause_dc1;
      dc3_cause <= dc2_cause;
      dc2_addr  <= bus.start_addr_dc1;
      dc3_addr  <= dc2_addr;
    end
  end

  // A dc3 fault counts only on a cycle where the pipe actually retires it.
  logic dc3_take;
  assign dc3_take = dc3_fault & ~bus.lsu_freeze_dc3 & ~bus.dec_tlu_flush_lower_wb;

  state_e            state_q, state_d;
  logic              capture;
  logic              ovf_q, ovf_d;
  logic [3:0]        cause_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dc3_take) begin
          capture = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (bus.tlu_fault_ack) begin
          ovf_d = 1'b0;
          if (dc3_take) capture = 1'b1;
          else          state_d = IDLE;
        end else if (dc3_take) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cause_q <= '0;
      addr_q  <= '0;
    end else if (capture) begin
      cause_q <= dc3_cause;
      addr_q  <= dc3_addr;
    end
  end

  // Saturating count of every retired dc3 fault, captured or dropped.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q <= '0;
    end else if (dc3_take && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.lsu_fault_valid    = (state_q == REPORT);
  assign bus.lsu_fault_cause    = cause_q;
  assign bus.lsu_fault_addr     = addr_q;
  assign bus.lsu_fault_overflow = ovf_q;
  assign bus.lsu_fault_cnt      = cnt_q;

endmodule

// File: tb/tb_lsu_fault_report.sv
// Directed bench for lsu_fault_report: a default instance and a CNT_W=2 instance
// share the same stimulus; expected values are hand-computed per step.
module tb_lsu_fault_report;

  logic        clk;
  logic        rst_l;
  logic        pkt_valid, pkt_dma, pkt_store, acc, mis, freeze, flush, ack;
  logic [31:0] addr;

  int checks   = 0;
  int failures = 0;

  lsu_fault_report_if #(.ADDR_W(32), .CNT_W(8)) bus_main ();
  lsu_fault_report_if #(.ADDR_W(32), .CNT_W(2)) bus_sat ();

  assign bus_main.lsu_pkt_valid_dc1      = pkt_valid;
  assign bus_main.lsu_pkt_dma_dc1        = pkt_dma;
  assign bus_main.lsu_pkt_store_dc1      = pkt_store;
  assign bus_main.start_addr_dc1         = addr;
  assign bus_main.access_fault_dc1       = acc;
  assign bus_main.misaligned_fault_dc1   = mis;
  assign bus_main.lsu_freeze_dc3         = freeze;
  assign bus_main.dec_tlu_flush_lower_wb = flush;
  assign bus_main.tlu_fault_ack          = ack;

  assign bus_sat.lsu_pkt_valid_dc1       = pkt_valid;
  assign bus_sat.lsu_pkt_dma_dc1         = pkt_dma;
  assign bus_sat.lsu_pkt_store_dc1       = pkt_store;
  assign bus_sat.start_addr_dc1          = addr;
  assign bus_sat.access_fault_dc1        = acc;
  assign bus_sat.misaligned_fault_dc1    = mis;
  assign bus_sat.lsu_freeze_dc3          = freeze;
  assign bus_sat.dec_tlu_flush_lower_wb  = flush;
  assign bus_sat.tlu_fault_ack           = ack;

  lsu_fault_report #(.ADDR_W(32), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus_main)
  );

  lsu_fault_report #(.ADDR_W(32), .CNT_W(2)) u_sat (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic store, input logic [31:0] a, input logic ac,
                       input logic mi, input logic dma);
    pkt_valid = 1'b1;
    pkt_dma   = dma;
    pkt_store = store;
    addr      = a;
    acc       = ac;
    mis       = mi;
  endtask

  task automatic idle_pkt();
    pkt_valid = 1'b0;
    pkt_dma   = 1'b0;
    pkt_store = 1'b0;
    acc       = 1'b0;
    mis       = 1'b0;
  endtask

  // One fault through an unfrozen pipe: valid is up once this returns.
  task automatic send_fault(input logic store, input logic [31:0] a,
                            input logic ac, input logic mi);
    drive(store, a, ac, mi, 1'b0);
    step();
    idle_pkt();
    step();
    step();
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    rst_l = 1'b0;
    freeze = 1'b0;
    flush  = 1'b0;
    ack    = 1'b0;
    addr   = '0;
    idle_pkt();
    #12;
    check("rst_valid", {31'd0, bus_main.lsu_fault_valid}, 32'd0);
    check("rst_cause", {28'd0, bus_main.lsu_fault_cause}, 32'd0);
    check("rst_addr",  bus_main.lsu_fault_addr, 32'd0);
    check("rst_ovf",   {31'd0, bus_main.lsu_fault_overflow}, 32'd0);
    check("rst_cnt",   {24'd0, bus_main.lsu_fault_cnt}, 32'd0);
    step();
    rst_l = 1'b1;
    step();

    // Load access fault: latency N+3, then ack drops valid.
    drive(1'b0, 32'h0000_1002, 1'b1, 1'b0, 1'b0);
    step();
    idle_pkt();
    step();
    check("t1_valid_early", {31'd0, bus_main.lsu_fault_valid}, 32'd0);
    step();
    check("t1_valid", {31'd0, bus_main.lsu_fault_valid}, 32'd1);
    check("t1_cause", {28'd0, bus_main.lsu_fault_cause}, 32'd5);
    check("t1_addr",  bus_main.lsu_fault_addr, 32'h0000_1002);
    check("t1_cnt",   {24'd0, bus_main.lsu_fault_cnt}, 32'd1);
    do_ack();
    check("t1_ack_valid", {31'd0, bus_main.lsu_fault_valid}, 32'd0);

    // Store: access outranks misaligned; misaligned alone gives 6.
    send_fault(1'b1, 32'h0000_2000, 1'b1, 1'b1);
    check("t2_both_cause", {28'd0, bus_main.lsu_fault_cause}, 32'd7);
    do_ack();
    send_fault(1'b1, 32'h0000_3003, 1'b0, 1'b1);
    check("t2_mis_cause", {28'd0, bus_main.lsu_fault_cause}, 32'd6);
    check("t2_mis_addr",  bus_main.lsu_fault_addr, 32'h0000_3003);
    do_ack();
    check("t2_cnt", {24'd0, bus_main.lsu_fault_cnt}, 32'd3);

    // DMA packet is never reported.
    drive(1'b0, 32'h0000_4000, 1'b1, 1'b1, 1'b1);
    step();
    idle_pkt();
    step();
    step();
    step();
    check("t3_dma_valid", {31'd0, bus_main.lsu_fault_valid}, 32'd0);
    check("t3_dma_cnt",   {24'd0, bus_main.lsu_fault_cnt}, 32'd3);

    // A presented, B dropped with overflow; ack clears it.
    drive(1'b0, 32'h0000_A000, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0000_B000, 1'b0, 1'b1, 1'b0);
    step();
    idle_pkt();
    step();
    step();
    check("t4_valid", {31'd0, bus_main.lsu_fault_valid}, 32'd1);
    check("t4_addr",  bus_main.lsu_fault_addr, 32'h0000_A000);
    check("t4_cause", {28'd0, bus_main.lsu_fault_cause}, 32'd5);
    check("t4_ovf",   {31'd0, bus_main.lsu_fault_overflow}, 32'd1);
    check("t4_cnt",   {24'd0, bus_main.lsu_fault_cnt}, 32'd5);
    do_ack();
    check("t4_ack_valid", {31'd0, bus_main.lsu_fault_valid}, 32'd0);
    check("t4_ack_ovf",   {31'd0, bus_main.lsu_fault_overflow}, 32'd0);
    do_ack();
    check("idle_ack_valid", {31'd0, bus_main.lsu_fault_valid}, 32'd0);
    check("idle_ack_cnt",   {24'd0, bus_main.lsu_fault_cnt}, 32'd5);

    // Frozen in dc2 for 3 cycles, then flushed: nothing reported.
    drive(1'b0, 32'h0000_5000, 1'b1, 1'b0, 1'b0);
    step();
    idle_pkt();
    freeze = 1'b1;
    repeat (3) step();
    freeze = 1'b0;
    flush  = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    check("t5_flush_valid", {31'd0, bus_main.lsu_fault_valid}, 32'd0);
    check("t5_flush_cnt",   {24'd0, bus_main.lsu_fault_cnt}, 32'd5);

    // Same without flush: reported 3 cycles later than the unfrozen case.
    drive(1'b0, 32'h0000_5004, 1'b1, 1'b0, 1'b0);
    step();
    idle_pkt();
    freeze = 1'b1;
    repeat (3) step();
    freeze = 1'b0;
    step();
    check("t5_frz_early", {31'd0, bus_main.lsu_fault_valid}, 32'd0);
    step();
    check("t5_frz_valid", {31'd0, bus_main.lsu_fault_valid}, 32'd1);
    check("t5_frz_addr",  bus_main.lsu_fault_addr, 32'h0000_5004);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_flush_keeps", {31'd0, bus_main.lsu_fault_valid}, 32'd1);
    check("t5_cnt", {24'd0, bus_main.lsu_fault_cnt}, 32'd6);

    // Reset while presenting: everything back to zero immediately.
    #2;
    rst_l = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, bus_main.lsu_fault_valid}, 32'd0);
    check("rst_mid_cnt",   {24'd0, bus_main.lsu_fault_cnt}, 32'd0);
    check("rst_mid_addr",  bus_main.lsu_fault_addr, 32'd0);
    step();
    rst_l = 1'b1;
    step();

    // Saturation on the CNT_W=2 instance.
    for (int i = 0; i < 5; i++) begin
      send_fault(1'b0, 32'h0000_0600 + i, 1'b1, 1'b0);
      check("t6_sat_valid", {31'd0, bus_sat.lsu_fault_valid}, 32'd1);
      check("t6_sat_cnt", {30'd0, bus_sat.lsu_fault_cnt}, (i < 3) ? i + 1 : 3);
      do_ack();
    end
    check("t6_main_cnt", {24'd0, bus_main.lsu_fault_cnt}, 32'd5);

    // Ack in the same cycle a new dc3 fault retires: valid never drops.
    drive(1'b0, 32'h0000_7000, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0000_7100, 1'b1, 1'b0, 1'b0);
    step();
    idle_pkt();
    step();
    check("t6_c_addr", bus_main.lsu_fault_addr, 32'h0000_7000);
    do_ack();
    check("t6_bb_valid", {31'd0, bus_main.lsu_fault_valid}, 32'd1);
    check("t6_bb_addr",  bus_main.lsu_fault_addr, 32'h0000_7100);
    check("t6_bb_cause", {28'd0, bus_main.lsu_fault_cause}, 32'd7);
    check("t6_bb_ovf",   {31'd0, bus_main.lsu_fault_overflow}, 32'd0);
    check("t6_bb_sat_addr", bus_sat.lsu_fault_addr, 32'h0000_7100);
    check("t6_bb_sat_cnt",  {30'd0, bus_sat.lsu_fault_cnt}, 32'd3);
    check("t6_bb_main_cnt", {24'd0, bus_main.lsu_fault_cnt}, 32'd7);
    do_ack();
    check("t6_end_valid", {31'd0, bus_main.lsu_fault_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
